cache_port_arbiter: RTL

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_arb_pkg.sv | 17 +
 rtl/arb_watchdog.sv | 29 ++
 rtl/cache_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache datapath port arbiter: FSM states and datapath owner.
// No logic here; imported by the arbiter and its watchdog.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    SNP_BUSY = 2'd2,
    RELEASE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_SNP = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts cycles while a grant is held, zeroed whenever no grant is active.
// Latency: expired is combinational from the count; no backpressure, pure observer.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The arbiter always passes through RELEASE between grants, so dropping
  // 'active' is enough to guarantee a zero count on every new grant.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active && (cnt == LIMIT);

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates the cache datapath between CPU requests and ACE snoops; readies combinational in IDLE, grant 1 cycle after accept.
// Backpressure: one owner at a time, held until done, then one RELEASE cycle; watchdog via CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int STREAK_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req_valid,
  output logic cpu_req_ready,
  input  logic cpu_done,
  input  logic snp_req_valid,
  output logic snp_req_ready,
  input  logic snp_done,
  output logic grant_cpu,
  output logic grant_snp,
  output logic dp_sel,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(STREAK_MAX);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q;
  logic [CNT_W-1:0] streak_cnt;
  logic             cpu_win, snp_win;
  logic             owner_done;
  logic             wd_expired;

  // Snoops normally win; a saturated streak hands one slot to the waiting CPU.
  always_comb begin
    cpu_win = cpu_req_valid && (!snp_req_valid || (streak_cnt == STREAK_LIM));
    snp_win = snp_req_valid && !cpu_win;
  end

  assign cpu_req_ready = (state_q == IDLE) && !reset && cpu_win;
  assign snp_req_ready = (state_q == IDLE) && !reset && snp_win;

  assign owner_done = ((state_q == CPU_BUSY) && cpu_done) ||
                      ((state_q == SNP_BUSY) && snp_done);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_ready) begin
          state_d = CPU_BUSY;
        end else if (snp_req_ready) begin
          state_d = SNP_BUSY;
        end
      end
      CPU_BUSY, SNP_BUSY: begin
        if (owner_done || wd_expired) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_cpu  <= 1'b0;
      grant_snp  <= 1'b0;
      owner_q    <= OWN_CPU;
      streak_cnt <= '0;
    end else begin
      state_q   <= state_d;
      grant_cpu <= (state_d == CPU_BUSY);
      grant_snp <= (state_d == SNP_BUSY);
      if (cpu_req_ready) begin
        owner_q    <= OWN_CPU;
        streak_cnt <= '0;
      end else if (snp_req_ready) begin
        owner_q <= OWN_SNP;
        if (!cpu_req_valid) begin
          streak_cnt <= '0;
        end else if (streak_cnt != STREAK_LIM) begin
          streak_cnt <= streak_cnt + 1'b1;
        end
      end
    end
  end

  assign dp_sel = (owner_q == OWN_SNP);
  assign busy   = (state_q != IDLE);

`ifdef CACHE_ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (grant_cpu || grant_snp),
    .expired(wd_expired)
  );

  // A done arriving on the expiry cycle is a normal release, not an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expired && !owner_done;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
